// File: rtl/matmul_pkg.sv
// Shared types, register map and helpers for the matmul controller.
// Imported by the bus interface and the controller.
package matmul_pkg;

    localparam logic [6:0] OFF_MAT1   = 7'h00;
    localparam logic [6:0] OFF_MAT2   = 7'h20;
    localparam logic [6:0] OFF_RES    = 7'h40;
    localparam logic [6:0] OFF_CTRL   = 7'h50;
    localparam logic [6:0] OFF_STATUS = 7'h54;
    localparam logic [6:0] OFF_OPCNT  = 7'h58;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        CAPTURE
    } state_t;

    typedef logic [1:0][3:0][31:0] mat24_t;
    typedef logic [3:0][1:0][31:0] mat42_t;
    typedef logic [1:0][1:0][31:0] mat22_t;

    function automatic logic [31:0] be_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  be
    );
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/matmul_bus_if.sv
// Single-cycle register bus between the bus master and the controller.
// The slave acks every request; reads answer one cycle later.
interface matmul_bus_if;
    import matmul_pkg::*;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ack;
    logic        resp;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  ack, resp, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output ack, resp, rdata
    );

endinterface

// File: rtl/matmul_ctrl.sv
// Register front end and sequencer for the 2x4 by 4x2 matrix datapath.
// Holds operands, pulses start, waits the datapath latency, snapshots RES.
module matmul_ctrl
    import matmul_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h2000_0000,
    parameter int          MATH_LATENCY = 4
) (
    input  logic         clk_gen,
    input  logic         srst,
    matmul_bus_if.slave  bus,
    output logic         math_start_o,
    output mat24_t       mat1_o,
    output mat42_t       mat2_o,
    input  mat22_t       res_i,
    output logic         busy_o,
    output logic         done_o
);

    // The register map spans 0x00..0x7C, so the window decodes 7 offset bits.
    localparam int CW = (MATH_LATENCY > 1) ? $clog2(MATH_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MATH_LATENCY - 1);

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;

    mat24_t        mat1_q;
    mat42_t        mat2_q;
    mat22_t        res_q;
    logic          done_q;
    logic          err_q;
    logic [31:0]   opcnt;

    logic          resp_q;
    logic [31:0]   rdata_q;
    logic [31:0]   rd_mux;

    logic [6:0]    off;
    logic          hit;
    logic          wr;
    logic          rd;
    logic          idle;
    logic          op_wr;
    logic          start_req;
    logic          clr_req;
    logic          sel_mat1;
    logic          sel_mat2;
    logic          sel_res;
    logic          sel_stat;
    logic          sel_cnt;
    logic          unused_ok;

    assign off       = bus.addr[6:0];
    assign hit       = (bus.addr[31:7] == BASE_ADDR[31:7]);
    assign wr        = bus.req & bus.we & hit;
    assign rd        = bus.req & ~bus.we & hit;
    assign idle      = (state == IDLE);
    assign op_wr     = wr & ~off[6];
    assign start_req = wr & (off == OFF_CTRL) & bus.wdata[0];
    assign clr_req   = wr & (off == OFF_CTRL) & bus.wdata[1];

    assign sel_mat1  = (off[6:5] == OFF_MAT1[6:5]);
    assign sel_mat2  = (off[6:5] == OFF_MAT2[6:5]);
    assign sel_res   = (off[6:4] == OFF_RES[6:4]);
    assign sel_stat  = (off == OFF_STATUS);
    assign sel_cnt   = (off == OFF_OPCNT);

    assign bus.ack   = bus.req;
    assign bus.resp  = resp_q;
    assign bus.rdata = rdata_q;
    assign mat1_o    = mat1_q;
    assign mat2_o    = mat2_q;
    assign unused_ok = &{1'b0, bus.addr[1:0]};

    // State register.
    always_ff @(posedge clk_gen) begin
        if (srst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next-state decode and FSM-driven outputs.
    always_comb begin
        state_nx     = state;
        math_start_o = 1'b0;
        busy_o       = 1'b1;
        unique case (state)
            IDLE: begin
                busy_o = 1'b0;
                if (start_req) state_nx = START;
            end
            START: begin
                math_start_o = 1'b1;
                state_nx     = WAIT;
            end
            WAIT: begin
                if (cnt == '0) state_nx = CAPTURE;
            end
            CAPTURE: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Latency counter: loaded in START, counts down through WAIT.
    always_ff @(posedge clk_gen) begin
        if (srst) begin
            cnt <= '0;
        end else if (state == START) begin
            cnt <= CNT_LOAD;
        end else if (state == WAIT && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Operand registers, byte-enable merged; frozen while an op is in flight.
    always_ff @(posedge clk_gen) begin
        if (srst) begin
            mat1_q <= '0;
            mat2_q <= '0;
        end else if (op_wr && idle) begin
            if (sel_mat1) begin
                mat1_q[off[4]][off[3:2]] <=
                    be_merge(mat1_q[off[4]][off[3:2]], bus.wdata, bus.be);
            end else begin
                mat2_q[off[4:3]][off[2]] <=
                    be_merge(mat2_q[off[4:3]][off[2]], bus.wdata, bus.be);
            end
        end
    end

    // Status flags, result snapshot and op counter.
    always_ff @(posedge clk_gen) begin
        if (srst) begin
            res_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            opcnt  <= '0;
            done_o <= 1'b0;
        end else begin
            done_o <= (state == CAPTURE);
            if (clr_req) begin
                done_q <= 1'b0;
                err_q  <= 1'b0;
            end
            if (!idle && (start_req || op_wr)) err_q <= 1'b1;
            if (state == CAPTURE) begin
                res_q  <= res_i;
                done_q <= 1'b1;
                opcnt  <= opcnt + 32'd1;
            end
        end
    end

    // Read data select for the addressed register.
    always_comb begin
        rd_mux = '0;
        unique case (1'b1)
            sel_mat1: rd_mux = mat1_q[off[4]][off[3:2]];
            sel_mat2: rd_mux = mat2_q[off[4:3]][off[2]];
            sel_res:  rd_mux = res_q[off[3]][off[2]];
            sel_stat: rd_mux = {29'd0, err_q, done_q, busy_o};
            sel_cnt:  rd_mux = opcnt;
            default:  rd_mux = '0;
        endcase
    end

    // Registered read response, one cycle after the request.
    always_ff @(posedge clk_gen) begin
        if (srst) begin
            resp_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            resp_q  <= rd;
            rdata_q <= rd ? rd_mux : 32'd0;
        end
    end

endmodule

// File: tb/tb_matmul_ctrl.sv
// Self-checking bench for matmul_ctrl with a behavioural datapath model.
// Read expectations are queued at issue and checked when the response lands.
module tb_matmul_ctrl;
    import matmul_pkg::*;

    localparam logic [31:0] BASE = 32'h2000_0000;
    localparam int          LAT  = 4;

    typedef struct {
        string       tag;
        logic [31:0] val;
        int          due;
    } exp_t;

    logic   clk_gen = 1'b0;
    logic   srst    = 1'b1;
    logic   math_start;
    mat24_t mat1;
    mat42_t mat2;
    mat22_t res     = '0;
    logic   busy;
    logic   done;

    int     n_chk   = 0;
    int     n_fail  = 0;
    int     cyc     = 0;
    int     n_done  = 0;
    int     mcnt    = 0;
    exp_t   exp_q[$];
    int     starts[$];

    mat24_t a1;
    mat42_t b1;
    mat22_t rexp;

    matmul_bus_if bus();

    matmul_ctrl #(
        .BASE_ADDR    (BASE),
        .MATH_LATENCY (LAT)
    ) dut (
        .clk_gen      (clk_gen),
        .srst         (srst),
        .bus          (bus.slave),
        .math_start_o (math_start),
        .mat1_o       (mat1),
        .mat2_o       (mat2),
        .res_i        (res),
        .busy_o       (busy),
        .done_o       (done)
    );

    always #5 clk_gen = ~clk_gen;

    // Cycle counter used for response due times and start spacing.
    always @(posedge clk_gen) cyc <= cyc + 1;

    function automatic mat22_t mat_mul(input mat24_t a, input mat42_t b);
        mat22_t r;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                r[i][j] = 32'd0;
                for (int k = 0; k < 4; k++) r[i][j] += a[i][k] * b[k][j];
            end
        return r;
    endfunction

    // Datapath model: garbage until LAT edges after start is sampled.
    always @(posedge clk_gen) begin
        if (math_start) begin
            mcnt <= LAT;
            res  <= {4{32'hDEAD_BEEF}};
        end else if (mcnt > 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) res <= mat_mul(mat1, mat2);
        end
    end

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Response monitor plus start/done pulse bookkeeping.
    always @(negedge clk_gen) begin
        if (math_start) starts.push_back(cyc);
        if (done) n_done++;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            if (bus.resp) chk(e.tag, bus.rdata, e.val);
            else          chk({e.tag, "_resp"}, 0, 1);
        end else if (bus.resp) begin
            chk("spurious_resp", 1, 0);
        end
    end

    task automatic bus_wr(input logic [31:0] addr, input logic [31:0] d,
                          input logic [3:0] be = 4'hF);
        bus.req   = 1'b1;
        bus.we    = 1'b1;
        bus.addr  = addr;
        bus.wdata = d;
        bus.be    = be;
        @(negedge clk_gen);
        chk("ack_wr", bus.ack, 1);
        bus.req = 1'b0;
        bus.we  = 1'b0;
    endtask

    task automatic bus_rd(input string tag, input logic [31:0] addr,
                          input logic [31:0] exp, input bit want = 1'b1);
        exp_t e;
        if (want) begin
            e.tag = tag;
            e.val = exp;
            e.due = cyc + 1;
            exp_q.push_back(e);
        end
        bus.req  = 1'b1;
        bus.we   = 1'b0;
        bus.addr = addr;
        @(negedge clk_gen);
        bus.req = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!done && k < 100) begin
            @(negedge clk_gen);
            k++;
        end
        chk(tag, done, 1);
    endtask

    task automatic load_mats();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++)
                bus_wr(BASE + 32'(r * 16 + c * 4), a1[r][c]);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 2; c++)
                bus_wr(BASE + 32'h20 + 32'(r * 8 + c * 4), b1[r][c]);
    endtask

    initial begin
        int d0;
        int s0;
        bus.req   = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        bus.be    = '0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++) a1[r][c] = 32'(r * 4 + c + 1);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 2; c++) b1[r][c] = 32'(r * 2 + c + 1);

        repeat (3) @(negedge clk_gen);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_start", math_start, 0);
        chk("rst_resp", bus.resp, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_mat1", mat1, 0);
        srst = 1'b0;
        bus_rd("rst_status", BASE + 32'h54, 0);
        bus_rd("rst_opcnt", BASE + 32'h58, 0);
        bus_rd("rst_res0", BASE + 32'h40, 0);

        // Basic operation.
        load_mats();
        chk("mat1_o", mat1, a1);
        chk("mat2_o", mat2, b1);
        rexp = mat_mul(a1, b1);
        d0 = n_done;
        s0 = starts.size();
        bus_wr(BASE + 32'h50, 32'h1);
        chk("start_hi", math_start, 1);
        chk("busy_hi", busy, 1);
        @(negedge clk_gen);
        chk("start_width", math_start, 0);
        repeat (LAT) @(negedge clk_gen);
        chk("busy_pre_cap", busy, 1);
        chk("done_pre_cap", done, 0);
        @(negedge clk_gen);
        chk("busy_post_cap", busy, 0);
        chk("done_cap", done, 1);
        @(negedge clk_gen);
        chk("done_pulse", done, 0);
        bus_rd("status_done", BASE + 32'h54, 32'h2);
        for (int i = 0; i < 4; i++)
            bus_rd("res", BASE + 32'h40 + 32'(i * 4), rexp[i / 2][i % 2]);
        bus_rd("opcnt1", BASE + 32'h58, 1);
        chk("done_count1", n_done - d0, 1);
        chk("start_count1", starts.size() - s0, 1);

        // Byte-enable merge on an operand write.
        bus_wr(BASE, 32'h1122_3344);
        bus_wr(BASE, 32'hAABB_CCDD, 4'b0101);
        bus_rd("be_merge", BASE, 32'h11BB_33DD);
        a1[0][0] = 32'h11BB_33DD;

        // Writes and starts while busy are dropped and raise ERR.
        s0 = starts.size();
        bus_wr(BASE + 32'h50, 32'h3);
        bus_wr(BASE + 32'h34, 32'h999);
        bus_wr(BASE + 32'h50, 32'h1);
        bus_rd("status_busy_err", BASE + 32'h54, 32'h5);
        chk("mat2_frozen", mat2, b1);
        wait_done("done_op2");
        bus_rd("status_after_op2", BASE + 32'h54, 32'h6);
        bus_wr(BASE + 32'h50, 32'h2);
        bus_rd("status_cleared", BASE + 32'h54, 0);
        bus_rd("mat2_5", BASE + 32'h34, b1[2][1]);
        rexp = mat_mul(a1, b1);
        bus_rd("res_op2", BASE + 32'h4C, rexp[1][1]);
        bus_rd("opcnt2", BASE + 32'h58, 2);
        chk("start_count2", starts.size() - s0, 1);

        // Reset during WAIT aborts the op.
        d0 = n_done;
        bus_wr(BASE + 32'h50, 32'h1);
        repeat (2) @(negedge clk_gen);
        srst = 1'b1;
        @(negedge clk_gen);
        srst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        repeat (LAT + 4) @(negedge clk_gen);
        chk("abort_no_done", n_done - d0, 0);
        bus_rd("abort_status", BASE + 32'h54, 0);
        bus_rd("abort_opcnt", BASE + 32'h58, 0);
        bus_rd("abort_res", BASE + 32'h40, 0);
        bus_rd("abort_mat1", BASE, 0);
        bus_rd("abort_mat2", BASE + 32'h20, 0);

        // Unmapped offsets and out-of-window accesses.
        s0 = starts.size();
        bus_wr(BASE + 32'h5C, 32'h1);
        bus_wr(BASE + 32'h80 + 32'h50, 32'h1);
        bus_wr(BASE + 32'h80, 32'h77);
        bus_rd("unmapped_5c", BASE + 32'h5C, 0);
        bus_rd("unmapped_7c", BASE + 32'h7C, 0);
        bus_rd("outside", BASE + 32'h80, 0, 1'b0);
        repeat (3) @(negedge clk_gen);
        chk("outside_no_start", starts.size() - s0, 0);
        chk("outside_no_busy", busy, 0);
        bus_rd("outside_mat1", BASE, 0);

        // Three back-to-back ops, each started in the first IDLE cycle.
        s0 = starts.size();
        for (int i = 0; i < 3; i++) begin
            bus_wr(BASE + 32'h50, 32'h1);
            wait_done("b2b_done");
        end
        @(negedge clk_gen);
        bus_rd("b2b_opcnt", BASE + 32'h58, 3);
        chk("b2b_starts", starts.size() - s0, 3);
        if (starts.size() - s0 == 3) begin
            chk("b2b_gap0", starts[s0 + 1] - starts[s0], LAT + 3);
            chk("b2b_gap1", starts[s0 + 2] - starts[s0 + 1], LAT + 3);
        end

        repeat (3) @(negedge clk_gen);
        chk("resp_pending", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
